// File: rtl/feature_blob_extractor.sv
// Groups lit runs of a 1-bit pixel stream into bounding-box blobs and emits one box per blob
// when it closes; re-times cameraVsync so the frame-end marker trails the frame's last feature.
module feature_blob_extractor #(
  parameter int NUM_BITS_X = 4,
  parameter int NUM_BITS_Y = 4,
  parameter int MAX_BLOBS  = 4
) (
  input  logic                                pixelClock,
  input  logic                                nReset,
  input  logic                                cameraHref,
  input  logic                                pixelValid,
  input  logic                                pixelBinary,
  input  logic                                cameraVsync,
  output logic                                featureValid,
  output logic [2*(NUM_BITS_X+NUM_BITS_Y)-1:0] featureVector,
  output logic                                cameraVsyncOut,
  output logic                                overflow
);
  localparam int FW = 2*(NUM_BITS_X+NUM_BITS_Y);
  localparam logic [NUM_BITS_X-1:0] X_MAX = '1;
  localparam logic [NUM_BITS_Y-1:0] Y_MAX = '1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  logic href_p0, pvld_p0, pix_p0, vsync_p0, href_p1, vsync_p1;
  logic pix_ok, lit, href_fall, vsync_rise, end_run;
  logic [NUM_BITS_X-1:0] x, rs, re, rs_p1, re_p1;
  logic [NUM_BITS_Y-1:0] y, ry_p1;
  logic in_run, close_p1, line_end_p1, frame_end_p1;

  state_t state, state_n;
  logic [MAX_BLOBS-1:0] valid, pending, touched, valid_n, pending_n, touched_n;
  logic [NUM_BITS_X-1:0] xmin [MAX_BLOBS];
  logic [NUM_BITS_X-1:0] xmax [MAX_BLOBS];
  logic [NUM_BITS_Y-1:0] ymin [MAX_BLOBS];
  logic [NUM_BITS_Y-1:0] ymax [MAX_BLOBS];
  logic [NUM_BITS_X-1:0] xmin_n [MAX_BLOBS];
  logic [NUM_BITS_X-1:0] xmax_n [MAX_BLOBS];
  logic [NUM_BITS_Y-1:0] ymin_n [MAX_BLOBS];
  logic [NUM_BITS_Y-1:0] ymax_n [MAX_BLOBS];
  logic emit, found, drop, flush_done;
  logic [FW-1:0] emit_vec;

  // Stage p0: input registers and edge-detect history
  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      href_p0  <= 1'b0;
      pvld_p0  <= 1'b0;
      vsync_p0 <= 1'b0;
      href_p1  <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      href_p0  <= cameraHref;
      pvld_p0  <= pixelValid;
      vsync_p0 <= cameraVsync;
      href_p1  <= href_p0;
      vsync_p1 <= vsync_p0;
    end
  end

  always_ff @(posedge pixelClock) pix_p0 <= pixelBinary;

  // Stage p1: coordinate counters and run detection
  assign pix_ok     = href_p0 & pvld_p0;
  assign lit        = pix_ok & pix_p0 & (x != X_MAX) & (y != Y_MAX);
  assign href_fall  = href_p1 & ~href_p0;
  assign vsync_rise = vsync_p0 & ~vsync_p1;
  assign end_run    = in_run & ((pix_ok & ~lit) | href_fall | vsync_rise);

  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      x            <= '0;
      y            <= '0;
      in_run       <= 1'b0;
      close_p1     <= 1'b0;
      line_end_p1  <= 1'b0;
      frame_end_p1 <= 1'b0;
    end else begin
      if (!href_p0) x <= '0;
      else if (pvld_p0 && x != X_MAX) x <= x + 1'b1;
      if (vsync_rise) y <= '0;
      else if (href_fall && y != Y_MAX) y <= y + 1'b1;
      if (lit) in_run <= 1'b1;
      else if (end_run) in_run <= 1'b0;
      close_p1     <= end_run;
      line_end_p1  <= href_fall;
      frame_end_p1 <= vsync_rise;
    end
  end

  always_ff @(posedge pixelClock) begin
    if (lit && !in_run) rs <= x;
    if (lit) re <= x;
    rs_p1 <= rs;
    re_p1 <= re;
    ry_p1 <= y;
  end

  // Stage p2: slot merge/allocate, pending marking, emission and sequencing
  always_comb begin
    valid_n    = valid;
    pending_n  = pending;
    touched_n  = touched;
    xmin_n     = xmin;
    xmax_n     = xmax;
    ymin_n     = ymin;
    ymax_n     = ymax;
    emit       = 1'b0;
    emit_vec   = '0;
    found      = 1'b0;
    drop       = 1'b0;
    flush_done = 1'b0;
    state_n    = state;

    if (state != IDLE) begin
      for (int i = 0; i < MAX_BLOBS; i++) begin
        if (pending[i] && !emit) begin
          emit         = 1'b1;
          emit_vec     = {xmin[i], ymin[i], xmax[i], ymax[i]};
          valid_n[i]   = 1'b0;
          pending_n[i] = 1'b0;
        end
      end
    end

    if (close_p1) begin
      for (int i = 0; i < MAX_BLOBS; i++) begin
        if (!found && valid[i] && !pending[i] && rs_p1 <= xmax[i] && re_p1 >= xmin[i]) begin
          found = 1'b1;
          if (rs_p1 < xmin[i]) xmin_n[i] = rs_p1;
          if (re_p1 > xmax[i]) xmax_n[i] = re_p1;
          ymax_n[i]    = ry_p1;
          touched_n[i] = 1'b1;
        end
      end
      for (int i = 0; i < MAX_BLOBS; i++) begin
        if (!found && !valid[i]) begin
          found        = 1'b1;
          valid_n[i]   = 1'b1;
          pending_n[i] = 1'b0;
          touched_n[i] = 1'b1;
          xmin_n[i]    = rs_p1;
          xmax_n[i]    = re_p1;
          ymin_n[i]    = ry_p1;
          ymax_n[i]    = ry_p1;
        end
      end
      drop = !found;
    end

    // Merges from the run closing on this same edge must count as touches first.
    if (line_end_p1) pending_n = pending_n | (valid_n & ~touched_n);
    if (frame_end_p1) pending_n = pending_n | valid_n;
    if (line_end_p1 || frame_end_p1) touched_n = '0;

    unique case (state)
      IDLE: begin
        if (frame_end_p1) state_n = FLUSH;
        else if (line_end_p1) state_n = DRAIN;
      end
      DRAIN: begin
        if (frame_end_p1) state_n = FLUSH;
        else if (!line_end_p1 && pending == '0) state_n = IDLE;
      end
      FLUSH: begin
        if (!frame_end_p1 && !line_end_p1 && pending == '0) begin
          state_n    = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pixelClock or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      valid          <= '0;
      pending        <= '0;
      touched        <= '0;
      featureValid   <= 1'b0;
      featureVector  <= '0;
      cameraVsyncOut <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state        <= state_n;
      valid        <= valid_n;
      pending      <= pending_n;
      touched      <= touched_n;
      featureValid <= emit;
      if (emit) featureVector <= emit_vec;
      if (!vsync_p0) cameraVsyncOut <= 1'b0;
      else if (flush_done) cameraVsyncOut <= 1'b1;
      if (flush_done && vsync_p0) overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge pixelClock) begin
    xmin <= xmin_n;
    xmax <= xmax_n;
    ymin <= ymin_n;
    ymax <= ymax_n;
  end

endmodule

// File: tb/tb_feature_blob_extractor.sv
// Bench for feature_blob_extractor: frame images are reduced to expected bounding boxes by a
// line-by-line blob model; a monitor compares every featureValid pulse against that queue.
module tb_feature_blob_extractor;
  localparam int NX = 4;
  localparam int NY = 4;
  localparam int MB = 4;
  localparam int FW = 2*(NX+NY);

  logic clk = 1'b0;
  logic nReset, cameraHref, pixelValid, pixelBinary, cameraVsync;
  logic featureValid, cameraVsyncOut, overflow;
  logic [FW-1:0] featureVector;

  always #5 clk = ~clk;

  feature_blob_extractor #(.NUM_BITS_X(NX), .NUM_BITS_Y(NY), .MAX_BLOBS(MB)) dut (
    .pixelClock(clk), .nReset(nReset), .cameraHref(cameraHref), .pixelValid(pixelValid),
    .pixelBinary(pixelBinary), .cameraVsync(cameraVsync), .featureValid(featureValid),
    .featureVector(featureVector), .cameraVsyncOut(cameraVsyncOut), .overflow(overflow)
  );

  logic [FW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit img [16][16];
  int nlines;
  bit exp_ovf;
  bit chk_adjacent = 1'b0;
  bit fv_prev = 1'b0;
  bit vo_prev = 1'b0;
  bit mv[MB];
  bit mt[MB];
  int mxn[MB], myn[MB], mxx[MB], myx[MB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the next expected box; vsync-out must trail all boxes.
  always @(negedge clk) begin
    if (nReset) begin
      if (featureValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_feature actual=%0h required=none", featureVector);
        end else begin
          check("feature", 32'(featureVector), 32'(exp_q.pop_front()));
        end
      end
      if (cameraVsyncOut && !vo_prev) begin
        check("features_before_vsync_out", exp_q.size(), 0);
        if (chk_adjacent) check("vsync_out_one_after_last_feature", 32'(fv_prev), 1);
      end
    end
    fv_prev = featureValid;
    vo_prev = cameraVsyncOut;
  end

  task automatic clear_img();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = 1'b0;
  endtask

  task automatic square(input int x0, input int x1, input int y0, input int y1);
    for (int r = y0; r <= y1; r++)
      for (int c = x0; c <= x1; c++) img[r][c] = 1'b1;
  endtask

  task automatic place_run(input int rs, input int re, input int y);
    int hit;
    hit = -1;
    for (int i = 0; i < MB; i++)
      if (hit < 0 && mv[i] && rs <= mxx[i] && re >= mxn[i]) hit = i;
    if (hit >= 0) begin
      if (rs < mxn[hit]) mxn[hit] = rs;
      if (re > mxx[hit]) mxx[hit] = re;
      myx[hit] = y;
      mt[hit] = 1'b1;
    end else begin
      for (int i = 0; i < MB; i++) if (hit < 0 && !mv[i]) hit = i;
      if (hit >= 0) begin
        mv[hit] = 1'b1; mt[hit] = 1'b1;
        mxn[hit] = rs; mxx[hit] = re; myn[hit] = y; myx[hit] = y;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic emit_slot(input int i);
    exp_q.push_back({4'(mxn[i]), 4'(myn[i]), 4'(mxx[i]), 4'(myx[i])});
    mv[i] = 1'b0;
  endtask

  task automatic model_frame();
    exp_ovf = 1'b0;
    for (int i = 0; i < MB; i++) begin mv[i] = 1'b0; mt[i] = 1'b0; end
    for (int y = 0; y < nlines; y++) begin
      int rs;
      bit lit;
      rs = -1;
      for (int x = 0; x < 16; x++) begin
        lit = 1'b0;
        if (x < 15 && y < 15) lit = img[y][x];
        if (lit && rs < 0) rs = x;
        else if (!lit && rs >= 0) begin place_run(rs, x-1, y); rs = -1; end
      end
      if (rs >= 0) place_run(rs, 14, y);
      for (int i = 0; i < MB; i++) if (mv[i] && !mt[i]) emit_slot(i);
      for (int i = 0; i < MB; i++) mt[i] = 1'b0;
    end
    for (int i = 0; i < MB; i++) if (mv[i]) emit_slot(i);
  endtask

  task automatic send_lines(input int n);
    for (int y = 0; y < n; y++) begin
      for (int x = 0; x < 16; x++) begin
        while ($urandom_range(0, 3) == 0) begin
          cameraHref = 1'b1; pixelValid = 1'b0; pixelBinary = 1'($urandom);
          @(negedge clk);
        end
        cameraHref = 1'b1; pixelValid = 1'b1; pixelBinary = img[y][x];
        @(negedge clk);
      end
      cameraHref = 1'b0;
      for (int b = 0; b < 12; b++) begin
        pixelValid = 1'($urandom); pixelBinary = 1'b1;
        @(negedge clk);
      end
      pixelValid = 1'b0; pixelBinary = 1'b0;
    end
  endtask

  task automatic end_frame(input bit adjacent);
    int n;
    chk_adjacent = adjacent;
    check("overflow_before_frame_end", 32'(overflow), 32'(exp_ovf));
    cameraVsync = 1'b1;
    n = 0;
    while (!cameraVsyncOut && n < 200) begin @(negedge clk); n++; end
    if (!cameraVsyncOut) begin
      checks++;
      failures++;
      $display("FAIL vsync_out_timeout actual=0 required=1");
    end else begin
      check("overflow_cleared_at_vsync_out", 32'(overflow), 0);
    end
    repeat (3) @(negedge clk);
    cameraVsync = 1'b0;
    @(negedge clk);
    check("vsync_out_hold", 32'(cameraVsyncOut), 1);
    @(negedge clk);
    check("vsync_out_fall", 32'(cameraVsyncOut), 0);
    chk_adjacent = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int n, input bit adjacent);
    nlines = n;
    model_frame();
    send_lines(n);
    end_frame(adjacent);
  endtask

  initial begin
    nReset = 1'b0; cameraHref = 1'b0; pixelValid = 1'b0; pixelBinary = 1'b0; cameraVsync = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_featureValid", 32'(featureValid), 0);
    check("reset_featureVector", 32'(featureVector), 0);
    check("reset_vsync_out", 32'(cameraVsyncOut), 0);
    check("reset_overflow", 32'(overflow), 0);
    nReset = 1'b1;
    repeat (3) @(negedge clk);

    clear_img(); square(2, 4, 1, 3);
    run_frame(8, 1'b0);

    clear_img(); square(0, 1, 0, 1); square(5, 6, 0, 2);
    run_frame(8, 1'b0);

    clear_img(); square(3, 5, 4, 7);
    run_frame(8, 1'b1);

    clear_img();
    for (int k = 0; k < 5; k++) img[0][2*k] = 1'b1;
    run_frame(4, 1'b0);

    clear_img(); square(13, 15, 1, 2);
    run_frame(5, 1'b0);

    clear_img(); square(2, 4, 1, 3);
    send_lines(2);
    cameraHref = 1'b1; pixelValid = 1'b1; pixelBinary = 1'b0;
    repeat (2) @(negedge clk);
    pixelBinary = 1'b1;
    repeat (2) @(negedge clk);
    nReset = 1'b0;
    cameraHref = 1'b0; pixelValid = 1'b0; pixelBinary = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_featureValid", 32'(featureValid), 0);
    check("midreset_overflow", 32'(overflow), 0);
    nReset = 1'b1;
    repeat (30) @(negedge clk);
    run_frame(8, 1'b0);

    for (int f = 0; f < 8; f++) begin
      int dens;
      dens = $urandom_range(10, 45);
      clear_img();
      for (int r = 0; r < 15; r++)
        for (int c = 0; c < 16; c++) img[r][c] = ($urandom_range(0, 99) < dens);
      run_frame($urandom_range(6, 15), 1'b0);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
